// File: rtl/checkout_pkg.sv
// Shared types and constants for the checkout sequencer and its round-robin arbiter.
// The state type is also what the sequencer drives onto its fsm_state debug port.
package checkout_pkg;

    localparam int ITEM_W  = 640;
    localparam int QTY_W   = 8;
    localparam int CENTS_W = 16;
    localparam logic [CENTS_W-1:0] ERR_TOTAL = 16'd9999;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_SETUP = 3'd1,
        LD_PULSE = 3'd2,
        EQ_SETUP = 3'd3,
        EQ_PULSE = 3'd4,
        CAPTURE  = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin lane arbiter: the search starts one past the last granted lane.
// The pointer moves only when the sequencer takes the grant (advance).
module rr_arbiter #(
    parameter int N_LANES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_LANES-1:0]         req,
    input  logic [N_LANES-1:0]         mask,
    input  logic                       advance,
    output logic [N_LANES-1:0]         grant_onehot,
    output logic [$clog2(N_LANES)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N_LANES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_LANES - 1);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cand;
    logic [N_LANES-1:0] eligible;
    logic               found;

    // Masked lanes (acked this cycle) cannot win even if their request is still up.
    assign eligible = req & ~mask;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int i = 0; i < N_LANES; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_LANES);
            if (!found && eligible[cand]) begin
                found              = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/checkout_sequencer.sv
// Shares one event-driven price calculator between N_LANES checkout lanes and a price-load port,
// sequencing setup/strobe/capture and keeping a saturating grand total of good lookups.
module checkout_sequencer
    import checkout_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int TOTAL_W = 24
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_LANES-1:0]         lane_req,
    input  logic [N_LANES*ITEM_W-1:0]  lane_item,
    input  logic [N_LANES*QTY_W-1:0]   lane_qty,
    output logic [N_LANES-1:0]         lane_ack,
    output logic                       rsp_valid,
    output logic [$clog2(N_LANES)-1:0] rsp_lane,
    output logic [CENTS_W-1:0]         rsp_total,
    output logic                       rsp_err,
    input  logic                       ld_valid,
    input  logic [ITEM_W-1:0]          ld_item,
    input  logic [CENTS_W-1:0]         ld_price,
    output logic                       ld_ready,
    output logic                       ld_done,
    input  logic                       grand_clr,
    output logic [TOTAL_W-1:0]         grand_total,
    output logic                       grand_sat,
    output logic                       calc_reset,
    output logic                       calc_load,
    output logic                       calc_equals,
    output logic [ITEM_W-1:0]          calc_item,
    output logic [QTY_W-1:0]           calc_qty,
    output logic [CENTS_W-1:0]         calc_price_in_cents,
    input  logic [CENTS_W-1:0]         calc_total_in_cents,
    input  logic                       calc_err,
    output logic [2:0]                 fsm_state
);

    localparam int IDX_W = $clog2(N_LANES);

    state_t               state, next_state;
    logic [N_LANES-1:0]   grant_onehot, cur_onehot;
    logic [IDX_W-1:0]     grant_idx, cur_lane;
    logic                 any_req, start_load, start_lookup, capture;
    logic [TOTAL_W-1:0]   base_total, grand_next;
    logic [TOTAL_W:0]     sum;
    logic                 base_sat, sat_next;

    // Handshakes: a load transfers on a cycle where ld_valid && ld_ready; a lane holds
    // lane_req until its one-cycle lane_ack, which coincides with rsp_valid for that lane.
    assign ld_ready  = (state == IDLE) && reset_n;
    assign any_req   = |(lane_req & ~lane_ack);
    assign fsm_state = state;

    rr_arbiter #(.N_LANES(N_LANES)) u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (lane_req),
        .mask         (lane_ack),
        .advance      (start_lookup),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_comb begin
        next_state   = state;
        start_load   = 1'b0;
        start_lookup = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_valid) begin
                    start_load = 1'b1;
                    next_state = LD_SETUP;
                end else if (any_req) begin
                    start_lookup = 1'b1;
                    next_state   = EQ_SETUP;
                end
            end
            LD_SETUP: next_state = LD_PULSE;
            LD_PULSE: next_state = IDLE;
            EQ_SETUP: next_state = EQ_PULSE;
            EQ_PULSE: next_state = CAPTURE;
            CAPTURE: begin
                capture    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Clear is applied before the add, so a clear on a capture edge leaves just that capture.
    always_comb begin
        base_total = grand_clr ? '0 : grand_total;
        base_sat   = grand_clr ? 1'b0 : grand_sat;
        sum        = {1'b0, base_total} + (TOTAL_W + 1)'(calc_total_in_cents);
        grand_next = base_total;
        sat_next   = base_sat;
        if (capture && !calc_err) begin
            if (sum[TOTAL_W]) begin
                grand_next = '1;
                sat_next   = 1'b1;
            end else begin
                grand_next = sum[TOTAL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= IDLE;
            calc_reset          <= 1'b1;
            calc_load           <= 1'b0;
            calc_equals         <= 1'b0;
            calc_item           <= '0;
            calc_qty            <= '0;
            calc_price_in_cents <= '0;
            cur_lane            <= '0;
            cur_onehot          <= '0;
            lane_ack            <= '0;
            rsp_valid           <= 1'b0;
            rsp_lane            <= '0;
            rsp_total           <= '0;
            rsp_err             <= 1'b0;
            ld_done             <= 1'b0;
            grand_total         <= '0;
            grand_sat           <= 1'b0;
        end else begin
            state       <= next_state;
            calc_reset  <= 1'b0;
            // Strobes derive from the next state so they are low throughout both SETUP states.
            calc_load   <= (next_state == LD_PULSE);
            calc_equals <= (next_state == EQ_PULSE);
            ld_done     <= (state == LD_PULSE);
            rsp_valid   <= capture;
            lane_ack    <= capture ? cur_onehot : '0;
            if (start_load) begin
                calc_item           <= ld_item;
                calc_price_in_cents <= ld_price;
            end
            if (start_lookup) begin
                calc_item  <= lane_item[int'(grant_idx)*ITEM_W +: ITEM_W];
                calc_qty   <= lane_qty[int'(grant_idx)*QTY_W +: QTY_W];
                cur_lane   <= grant_idx;
                cur_onehot <= grant_onehot;
            end
            if (capture) begin
                rsp_lane  <= cur_lane;
                rsp_total <= calc_total_in_cents;
                rsp_err   <= calc_err;
            end
            grand_total <= grand_next;
            grand_sat   <= sat_next;
        end
    end

endmodule

// File: tb/tb_checkout_sequencer.sv
// Bench for checkout_sequencer: a behavioural calculator stub, directed scenarios and randomized
// batches, with a scoreboard queue filled at issue time and drained by an output monitor.
module tb_checkout_sequencer;

    localparam int N_LANES = 4;
    localparam int TOTAL_W = 16;
    localparam int ITEM_W  = 640;
    localparam int N_ITEMS = 6;
    localparam int MAXG    = 65535;
    localparam int EXP_W   = 38;
    localparam logic [EXP_W-1:0] LD_ENTRY = {1'b1, 37'd0};

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [N_LANES-1:0]        lane_req;
    logic [N_LANES*ITEM_W-1:0] lane_item;
    logic [N_LANES*8-1:0]      lane_qty;
    logic [N_LANES-1:0]        lane_ack;
    logic                      rsp_valid;
    logic [1:0]                rsp_lane;
    logic [15:0]               rsp_total;
    logic                      rsp_err;
    logic                      ld_valid;
    logic [ITEM_W-1:0]         ld_item;
    logic [15:0]               ld_price;
    logic                      ld_ready;
    logic                      ld_done;
    logic                      grand_clr;
    logic [TOTAL_W-1:0]        grand_total;
    logic                      grand_sat;
    logic                      calc_reset, calc_load, calc_equals;
    logic [ITEM_W-1:0]         calc_item;
    logic [7:0]                calc_qty;
    logic [15:0]               calc_price_in_cents;
    logic [15:0]               calc_total_in_cents = '0;
    logic                      calc_err = 1'b0;
    logic [2:0]                fsm_state;

    checkout_sequencer #(.N_LANES(N_LANES), .TOTAL_W(TOTAL_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .lane_req(lane_req), .lane_item(lane_item), .lane_qty(lane_qty), .lane_ack(lane_ack),
        .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_total(rsp_total), .rsp_err(rsp_err),
        .ld_valid(ld_valid), .ld_item(ld_item), .ld_price(ld_price),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .grand_clr(grand_clr), .grand_total(grand_total), .grand_sat(grand_sat),
        .calc_reset(calc_reset), .calc_load(calc_load), .calc_equals(calc_equals),
        .calc_item(calc_item), .calc_qty(calc_qty), .calc_price_in_cents(calc_price_in_cents),
        .calc_total_in_cents(calc_total_in_cents), .calc_err(calc_err),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- calculator stub (event driven, keyed by item name) ----------------
    logic [ITEM_W-1:0] cal_items[$];
    logic [15:0]       cal_prices[$];

    always @(posedge calc_reset or posedge calc_load or posedge calc_equals) begin
        int hit;
        hit = -1;
        foreach (cal_items[k]) if (cal_items[k] == calc_item) hit = k;
        if (calc_reset) begin
            cal_items.delete();
            cal_prices.delete();
        end else if (calc_load) begin
            if (hit >= 0) cal_prices[hit] = calc_price_in_cents;
            else begin
                cal_items.push_back(calc_item);
                cal_prices.push_back(calc_price_in_cents);
            end
        end else if (calc_equals) begin
            if (hit >= 0) begin
                calc_total_in_cents = calc_qty * cal_prices[hit];
                calc_err            = 1'b0;
            end else begin
                calc_total_in_cents = 16'd9999;
                calc_err            = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [ITEM_W-1:0] names[N_ITEMS];
    int  ref_price[N_ITEMS];
    bit  ref_loaded[N_ITEMS];
    int  ref_ptr;
    int  ref_grand;
    bit  ref_sat;

    int  checks = 0;
    int  errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    function automatic void ref_reset();
        foreach (ref_loaded[k]) ref_loaded[k] = 1'b0;
        ref_ptr   = 0;
        ref_grand = 0;
        ref_sat   = 1'b0;
    endfunction

    function automatic void ref_load(int item, int price);
        ref_loaded[item] = 1'b1;
        ref_price[item]  = price;
        exp_q.push_back(LD_ENTRY);
    endfunction

    function automatic logic [EXP_W-1:0] predict_lookup(int lane, int item, int qty, bit clr);
        int tot;
        bit err;
        if (clr) begin
            ref_grand = 0;
            ref_sat   = 1'b0;
        end
        if (ref_loaded[item]) begin
            tot = (qty * ref_price[item]) % 65536;
            err = 1'b0;
        end else begin
            tot = 9999;
            err = 1'b1;
        end
        if (!err) begin
            ref_grand = ref_grand + tot;
            if (ref_grand > MAXG) begin
                ref_grand = MAXG;
                ref_sat   = 1'b1;
            end
        end
        ref_ptr = (lane + 1) % N_LANES;
        return {1'b0, 3'(lane), err, 16'(tot), ref_sat, 16'(ref_grand)};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string name, input logic [EXP_W-1:0] act);
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got 0x%0h, expected no event", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(act), 64'(e));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (ld_done === 1'b1) pop_compare("ld_done_event", {1'b0, 37'd0} | LD_ENTRY);
            if (rsp_valid === 1'b1) begin
                pop_compare("rsp_event", {1'b0, 3'(rsp_lane), rsp_err, rsp_total, grand_sat, grand_total});
                check("lane_ack_onehot", 64'(lane_ack), 64'(4'b0001 << rsp_lane));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic set_lane(input int lane, input int item, input int qty);
        lane_item[lane*ITEM_W +: ITEM_W] = names[item];
        lane_qty[lane*8 +: 8]            = 8'(qty);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n   = 1'b0;
        lane_req  = '0;
        ld_valid  = 1'b0;
        grand_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ref_reset();
    endtask

    task automatic load_direct(input int item, input int price);
        @(negedge clk);
        ld_item  = names[item];
        ld_price = 16'(price);
        ld_valid = 1'b1;
        ref_load(item, price);
        @(negedge clk);
        ld_valid = 1'b0;
        check("ld_t1_calc_load", 64'(calc_load), 64'd0);
        check("ld_t1_price", 64'(calc_price_in_cents), 64'(price));
        @(negedge clk);
        check("ld_t2_calc_load", 64'(calc_load), 64'd1);
        @(negedge clk);
        check("ld_t3_calc_load", 64'(calc_load), 64'd0);
        check("ld_t3_ld_done", 64'(ld_done), 64'd1);
    endtask

    task automatic timed_lookup(input int lane, input int item, input int qty, input bit clr);
        exp_q.push_back(predict_lookup(lane, item, qty, clr));
        @(negedge clk);
        set_lane(lane, item, qty);
        lane_req[lane] = 1'b1;
        @(negedge clk);
        check("lk_t1_equals", 64'(calc_equals), 64'd0);
        @(negedge clk);
        check("lk_t2_equals", 64'(calc_equals), 64'd1);
        check("lk_t2_qty", 64'(calc_qty), 64'(qty));
        @(negedge clk);
        check("lk_t3_equals", 64'(calc_equals), 64'd0);
        check("lk_t3_rsp_valid", 64'(rsp_valid), 64'd0);
        grand_clr = clr;
        @(negedge clk);
        check("lk_t4_rsp_valid", 64'(rsp_valid), 64'd1);
        check("lk_t4_lane_ack", 64'(lane_ack), 64'(4'b0001 << lane));
        grand_clr      = 1'b0;
        lane_req[lane] = 1'b0;
        @(negedge clk);
        check("lk_t5_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    int b_item[N_LANES];
    int b_qty[N_LANES];

    task automatic run_batch(input logic [N_LANES-1:0] m, input bit do_ld, input int ld_idx,
                             input int ld_pr, input bit ld_late);
        int  order[$];
        int  budget;
        bit  pend;
        if (m == '0 && !do_ld) return;
        for (int k = 0; k < N_LANES; k++) begin
            int l;
            l = (ref_ptr + k) % N_LANES;
            if (m[l]) order.push_back(l);
        end
        if (do_ld && (!ld_late || order.size() == 0)) ref_load(ld_idx, ld_pr);
        foreach (order[j]) begin
            exp_q.push_back(predict_lookup(order[j], b_item[order[j]], b_qty[order[j]], 1'b0));
            if (j == 0 && do_ld && ld_late) ref_load(ld_idx, ld_pr);
        end
        @(negedge clk);
        for (int l = 0; l < N_LANES; l++) set_lane(l, b_item[l], b_qty[l]);
        lane_req = m;
        ld_item  = names[ld_idx];
        ld_price = 16'(ld_pr);
        if (do_ld && !ld_late) ld_valid = 1'b1;
        pend   = do_ld && ld_late;
        budget = 0;
        while (1) begin
            @(negedge clk);
            if (pend) begin
                ld_valid = 1'b1;
                pend     = 1'b0;
            end
            lane_req = lane_req & ~lane_ack;
            if (ld_done) ld_valid = 1'b0;
            if (exp_q.size() == 0 && lane_req == '0 && !ld_valid) break;
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL batch_timeout: got %0d pending events, expected 0", exp_q.size());
                lane_req = '0;
                ld_valid = 1'b0;
                exp_q.delete();
                break;
            end
        end
    endtask

    task automatic clear_total();
        @(negedge clk);
        grand_clr = 1'b1;
        @(negedge clk);
        grand_clr = 1'b0;
        ref_grand = 0;
        ref_sat   = 1'b0;
        check("clr_total", 64'({grand_sat, grand_total}), 64'({ref_sat, 16'(ref_grand)}));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        names[0] = ITEM_W'("apple");
        names[1] = ITEM_W'("pear");
        names[2] = ITEM_W'("kiwi");
        names[3] = ITEM_W'("gold");
        names[4] = ITEM_W'("silver");
        names[5] = ITEM_W'("bread");
        reset_n   = 1'b0;
        lane_req  = '0;
        lane_item = '0;
        lane_qty  = '0;
        ld_valid  = 1'b0;
        ld_item   = '0;
        ld_price  = '0;
        grand_clr = 1'b0;
        ref_reset();

        // Reset values held for three cycles, then release.
        repeat (3) begin
            @(negedge clk);
            check("rst_calc_reset", 64'(calc_reset), 64'd1);
            check("rst_ld_ready", 64'(ld_ready), 64'd0);
            check("rst_outs_a", {lane_ack, rsp_valid, rsp_lane, rsp_total, rsp_err, ld_done,
                                 grand_total, grand_sat, calc_load, calc_equals}, 64'd0);
            check("rst_outs_b", 64'({calc_qty, calc_price_in_cents, |calc_item}), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_calc_reset", 64'(calc_reset), 64'd0);
        check("rel_ld_ready", 64'(ld_ready), 64'd1);

        // Basic load + priced lookup, then an unknown item.
        load_direct(0, 125);
        timed_lookup(1, 0, 3, 1'b0);
        timed_lookup(2, 1, 5, 1'b0);

        // All lanes at once, load arriving during lane 0's transaction.
        reset_dut();
        for (int l = 0; l < N_LANES; l++) begin
            b_item[l] = 2;
            b_qty[l]  = l + 1;
        end
        run_batch(4'b1111, 1'b1, 2, 50, 1'b1);

        // Saturation, then clear coinciding with an accumulating capture.
        reset_dut();
        load_direct(3, 60000);
        timed_lookup(0, 3, 1, 1'b0);
        load_direct(4, 10000);
        timed_lookup(0, 4, 1, 1'b0);
        load_direct(5, 250);
        timed_lookup(0, 5, 2, 1'b1);

        // Reset during EQ_PULSE aborts the lookup and wipes the price list.
        load_direct(0, 125);
        @(negedge clk);
        set_lane(2, 0, 1);
        lane_req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_equals_high", 64'(calc_equals), 64'd1);
        reset_n  = 1'b0;
        lane_req = '0;
        @(negedge clk);
        check("abort_calc_reset", 64'(calc_reset), 64'd1);
        check("abort_no_ack", 64'({rsp_valid, lane_ack}), 64'd0);
        reset_n = 1'b1;
        ref_reset();
        @(negedge clk);
        check("abort_calc_reset_low", 64'(calc_reset), 64'd0);
        repeat (3) @(negedge clk);
        timed_lookup(2, 0, 1, 1'b0);

        // Randomized batches against the reference model.
        for (int n = 0; n < 40; n++) begin
            for (int l = 0; l < N_LANES; l++) begin
                b_item[l] = $urandom_range(0, N_ITEMS - 1);
                b_qty[l]  = $urandom_range(0, 255);
            end
            run_batch(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, N_ITEMS - 1), $urandom_range(1, 600),
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) clear_total();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
